// File: rtl/fp_operand_compare_swap.sv
// fp_operand_compare_swap
//   This is the front-end stage of the floating-point add/subtract datapath.
//   It captures two operands and the requested operation. It compares the
//   operand magnitudes one CHUNK-bit slice per cycle, starting with the most
//   significant slice. It then presents the operands ordered as
//   larger (DMP_o) and smaller (DmP_o) magnitude, together with the GT/EQ
//   flags and the raw operand signs.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start_i         request, accepted only while ready_o=1
//   Data_X_i/Y_i    operands (sign + exponent + significand), W bits
//   Add_Subt_i      requested operation (1=subtract, 0=add)
//   ready_o         idle, can accept start_i
//   valid_o         result valid, held until ack_i
//   ack_i           consumer accepts the result
//   DMP_o / DmP_o   larger / smaller magnitude (W-1 bits)
//   Sgn_X_o/Sgn_Y_o captured sign bits
//   Add_Subt_o      captured operation
//   GT_o / EQ_o     |X| > |Y| / |X| == |Y|
module fp_operand_compare_swap #(
    parameter int unsigned W     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] Data_X_i,
    input  logic [W-1:0] Data_Y_i,
    input  logic         Add_Subt_i,
    output logic         ready_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [W-2:0] DMP_o,
    output logic [W-2:0] DmP_o,
    output logic         Sgn_X_o,
    output logic         Sgn_Y_o,
    output logic         Add_Subt_o,
    output logic         GT_o,
    output logic         EQ_o
);

    localparam int unsigned MAG_W = W - 1;
    localparam int unsigned NCH   = (MAG_W + CHUNK - 1) / CHUNK;
    localparam int unsigned EXT_W = NCH * CHUNK;
    localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, CMP, SWAP, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       x_q;
    logic [W-1:0]       y_q;
    logic               op_q;

    logic [EXT_W-1:0]   x_ext_c;
    logic [EXT_W-1:0]   y_ext_c;
    logic [CHUNK-1:0]   x_chunk_c;
    logic [CHUNK-1:0]   y_chunk_c;

    // Magnitudes are zero-extended at the MSB so that every chunk is full width.
    assign x_ext_c = EXT_W'(x_q[MAG_W-1:0]);
    assign y_ext_c = EXT_W'(y_q[MAG_W-1:0]);

    // Select chunk cnt; chunk 0 is the most significant slice.
    always_comb begin
        x_chunk_c = '0;
        y_chunk_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (cnt == CNT_W'(i)) begin
                x_chunk_c = x_ext_c[(NCH-1-i)*CHUNK +: CHUNK];
                y_chunk_c = y_ext_c[(NCH-1-i)*CHUNK +: CHUNK];
            end
        end
    end

    // Control sequence and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            op_q       <= 1'b0;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            DMP_o      <= '0;
            DmP_o      <= '0;
            Sgn_X_o    <= 1'b0;
            Sgn_Y_o    <= 1'b0;
            Add_Subt_o <= 1'b0;
            GT_o       <= 1'b0;
            EQ_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x_q     <= Data_X_i;
                        y_q     <= Data_Y_i;
                        op_q    <= Add_Subt_i;
                        cnt     <= '0;
                        GT_o    <= 1'b0;
                        EQ_o    <= 1'b0;
                        ready_o <= 1'b0;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    if (x_chunk_c != y_chunk_c) begin
                        GT_o  <= (x_chunk_c > y_chunk_c);
                        EQ_o  <= 1'b0;
                        state <= SWAP;
                    end else if (cnt == CNT_W'(NCH - 1)) begin
                        GT_o  <= 1'b0;
                        EQ_o  <= 1'b1;
                        state <= SWAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SWAP: begin
                    if (GT_o || EQ_o) begin
                        DMP_o <= x_q[MAG_W-1:0];
                        DmP_o <= y_q[MAG_W-1:0];
                    end else begin
                        DMP_o <= y_q[MAG_W-1:0];
                        DmP_o <= x_q[MAG_W-1:0];
                    end
                    Sgn_X_o    <= x_q[W-1];
                    Sgn_Y_o    <= y_q[W-1];
                    Add_Subt_o <= op_q;
                    state      <= DONE;
                end
                DONE: begin
                    // The first DONE cycle raises valid_o. An ack seen before
                    // valid_o is high is ignored.
                    if (!valid_o) begin
                        valid_o <= 1'b1;
                    end else if (ack_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_operand_compare_swap.sv
module tb_fp_operand_compare_swap;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] Data_X_i;
    logic [31:0] Data_Y_i;
    logic        Add_Subt_i;
    logic        ready_o;
    logic        valid_o;
    logic        ack_i;
    logic [30:0] DMP_o;
    logic [30:0] DmP_o;
    logic        Sgn_X_o;
    logic        Sgn_Y_o;
    logic        Add_Subt_o;
    logic        GT_o;
    logic        EQ_o;

    fp_operand_compare_swap #(.W(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .Data_X_i(Data_X_i), .Data_Y_i(Data_Y_i), .Add_Subt_i(Add_Subt_i),
        .ready_o(ready_o), .valid_o(valid_o), .ack_i(ack_i),
        .DMP_o(DMP_o), .DmP_o(DmP_o), .Sgn_X_o(Sgn_X_o), .Sgn_Y_o(Sgn_Y_o),
        .Add_Subt_o(Add_Subt_o), .GT_o(GT_o), .EQ_o(EQ_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] dmp;
        logic [30:0] dmps;
        logic        sx;
        logic        sy;
        logic        op;
        logic        gt;
        logic        eq;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Reference: integer magnitude compare; latency from first differing prefix.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
        exp_t e;
        logic [31:0] mx;
        logic [31:0] my;
        int d;
        mx = {1'b0, x[30:0]};
        my = {1'b0, y[30:0]};
        e.gt = (mx > my);
        e.eq = (mx == my);
        e.dmp  = (e.gt || e.eq) ? mx[30:0] : my[30:0];
        e.dmps = (e.gt || e.eq) ? my[30:0] : mx[30:0];
        e.sx = x[31];
        e.sy = y[31];
        e.op = op;
        d = 3;
        if (!e.eq) begin
            for (int i = 3; i >= 0; i--)
                if ((mx >> (8 * (3 - i))) != (my >> (8 * (3 - i)))) d = i;
        end
        e.lat = d + 3;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: compares each new result against the oldest expectation.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (valid_o && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(valid_o), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
                check("DMP_o", 64'(DMP_o), 64'(e.dmp));
                check("DmP_o", 64'(DmP_o), 64'(e.dmps));
                check("GT_o", 64'(GT_o), 64'(e.gt));
                check("EQ_o", 64'(EQ_o), 64'(e.eq));
                check("Sgn_X_o", 64'(Sgn_X_o), 64'(e.sx));
                check("Sgn_Y_o", 64'(Sgn_Y_o), 64'(e.sy));
                check("Add_Subt_o", 64'(Add_Subt_o), 64'(e.op));
            end
        end
        prev_v = valid_o;
    end

    // Issue one operation, optionally hold it in DONE while new starts are
    // offered, then acknowledge it.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic op, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!ready_o && n < 20) begin @(negedge clk); n++; end
        if (!ready_o) begin check("ready_timeout", 64'(ready_o), 64'(1)); return; end
        Data_X_i = x; Data_Y_i = y; Add_Subt_i = op; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        e = model(x, y, op);
        e.acc = cyc;
        exp_q.push_back(e);
        // Inputs after the accepting edge must not matter.
        Data_X_i = $urandom; Data_Y_i = $urandom; Add_Subt_i = 1'($urandom);
        n = 0;
        while (!valid_o && n < 20) begin @(negedge clk); n++; end
        if (!valid_o) begin
            check("valid_timeout", 64'(valid_o), 64'(1));
            void'(exp_q.pop_front());
            return;
        end
        for (int k = 0; k < hold; k++) begin
            Data_X_i = $urandom; Data_Y_i = $urandom; start_i = 1'b1;
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'(0));
            check("hold_valid", 64'(valid_o), 64'(1));
            check("hold_DMP", 64'(DMP_o), 64'(e.dmp));
            check("hold_DmP", 64'(DmP_o), 64'(e.dmps));
            check("hold_GT", 64'(GT_o), 64'(e.gt));
        end
        start_i = 1'b0;
        ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack_i = 1'b0;
        check("post_ack_valid", 64'(valid_o), 64'(0));
        check("post_ack_ready", 64'(ready_o), 64'(1));
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        rst = 1'b1; start_i = 1'b0; ack_i = 1'b0;
        Data_X_i = '0; Data_Y_i = '0; Add_Subt_i = 1'b0;
        #12;
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_outs", 64'({DMP_o, DmP_o, Sgn_X_o, Sgn_Y_o, Add_Subt_o, GT_o, EQ_o}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 0);
        run_op(32'h3F80_0000, 32'hC000_0000, 1'b1, 0);
        run_op(32'h3F80_0001, 32'h3F80_0000, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0000, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5679, 1'b1, 10);
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 0);

        // Reset while comparing: in-flight operation is discarded.
        @(negedge clk);
        Data_X_i = 32'h3F80_0001; Data_Y_i = 32'h3F80_0000; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ready", 64'(ready_o), 64'(1));
        check("async_rst_valid", 64'(valid_o), 64'(0));
        check("async_rst_outs", 64'({DMP_o, DmP_o, Sgn_X_o, Sgn_Y_o, Add_Subt_o, GT_o, EQ_o}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_valid_after_rst", 64'(valid_o), 64'(0));
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 0);

        // Random operands covering every first-differing chunk and equal magnitudes.
        for (int t = 0; t < 60; t++) begin
            x = $urandom;
            case ($urandom_range(0, 2))
                0: y = $urandom;
                1: y = x ^ (32'h1 << $urandom_range(0, 30));
                default: y = {~x[31], x[30:0]};
            endcase
            run_op(x, y, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
